// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the sequential shifter: operation codes and FSM state encodings.
package shift_unit_seq_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_unit_seq_step.sv
// Combinational single-step shifter: shifts by k (0..STEP) bits and reports the last bit shifted out.
module shift_step
  import shift_unit_seq_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  i_data,
  input  shift_op_e     i_op,
  input  logic [KW-1:0] i_k,
  output logic [W-1:0]  o_data,
  output logic          o_carry
);

  int           w_k;
  logic [W-1:0] w_pre;

  always_comb begin
    w_k     = int'(i_k);
    w_pre   = i_data;
    o_data  = i_data;
    o_carry = 1'b0;
    case (i_op)
      OP_SRL: o_data = i_data >> w_k;
      OP_SRA: o_data = $signed(i_data) >>> w_k;
      OP_SLL: o_data = i_data << w_k;
      OP_ROR: o_data = (i_data >> w_k) | (i_data << (W - w_k));
      default: o_data = i_data;
    endcase
    // Pre-shifting by k-1 puts the last departing bit at the edge, avoiding a variable index.
    if (w_k != 0) begin
      case (i_op)
        OP_SRL, OP_SRA: begin
          w_pre   = i_data >> (w_k - 1);
          o_carry = w_pre[0];
        end
        OP_SLL: begin
          w_pre   = i_data << (w_k - 1);
          o_carry = w_pre[W-1];
        end
        default: o_carry = o_data[W-1];
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle SRL/SRA/SLL/ROR shifter: shifts up to STEP bits per clock between valid/ready handshakes.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1,
  localparam int AW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero
);

  localparam int KW = $clog2(STEP + 1);

  shift_state_e  r_state;
  shift_state_e  w_stateNext;
  logic [W-1:0]  r_data;
  shift_op_e     r_op;
  logic [AW-1:0] r_rem;
  logic          r_carry;
  logic [KW-1:0] w_k;
  logic [AW-1:0] w_remNext;
  logic [W-1:0]  w_stepData;
  logic          w_stepCarry;

  always_comb begin
    if (int'(r_rem) >= STEP) w_k = KW'(STEP);
    else                     w_k = KW'(r_rem);
    w_remNext = r_rem - AW'(w_k);
  end

  shift_step #(.W(W), .STEP(STEP)) u_step (
    .i_data  (r_data),
    .i_op    (r_op),
    .i_k     (w_k),
    .o_data  (w_stepData),
    .o_carry (w_stepCarry)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_stateNext = (in_amt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (w_remNext == '0) w_stateNext = ST_DONE;
      ST_DONE:  if (out_ready) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge; a zero amount leaves data untouched with carry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_op    <= OP_SRL;
      r_rem   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_op    <= shift_op_e'(in_op);
            r_rem   <= in_amt;
            r_carry <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_data  <= w_stepData;
          r_carry <= w_stepCarry;
          r_rem   <= w_remNext;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_data;
  assign out_carry = r_carry;
  assign out_zero  = out_valid && (r_data == '0);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: W=8 at STEP=1 and STEP=4, plus W=16 random ops against a one-shot model.
module tb_shift_unit_seq;

  localparam logic [1:0] SRL = 2'b00;
  localparam logic [1:0] SRA = 2'b01;
  localparam logic [1:0] SLL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  inValid;
  logic [2:0]  outReady;
  logic [15:0] inData;
  logic [3:0]  inAmt;
  logic [1:0]  inOp;

  logic        inReadyA, outValidA, outCarryA, outZeroA;
  logic [7:0]  outDataA;
  logic        inReadyB, outValidB, outCarryB, outZeroB;
  logic [7:0]  outDataB;
  logic        inReadyC, outValidC, outCarryC, outZeroC;
  logic [15:0] outDataC;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.W(8), .STEP(1)) dutA (
    .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_ready(inReadyA),
    .in_data(inData[7:0]), .in_amt(inAmt[2:0]), .in_op(inOp),
    .out_valid(outValidA), .out_ready(outReady[0]), .out_data(outDataA),
    .out_carry(outCarryA), .out_zero(outZeroA)
  );

  shift_unit_seq #(.W(8), .STEP(4)) dutB (
    .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_ready(inReadyB),
    .in_data(inData[7:0]), .in_amt(inAmt[2:0]), .in_op(inOp),
    .out_valid(outValidB), .out_ready(outReady[1]), .out_data(outDataB),
    .out_carry(outCarryB), .out_zero(outZeroB)
  );

  shift_unit_seq #(.W(16), .STEP(2)) dutC (
    .clk(clk), .reset(reset), .in_valid(inValid[2]), .in_ready(inReadyC),
    .in_data(inData), .in_amt(inAmt), .in_op(inOp),
    .out_valid(outValidC), .out_ready(outReady[2]), .out_data(outDataC),
    .out_carry(outCarryC), .out_zero(outZeroC)
  );

  // Packs one instance's outputs as {ready, valid, carry, zero, data[15:0]}.
  function automatic logic [19:0] peek(input int sel);
    case (sel)
      0:       return {inReadyA, outValidA, outCarryA, outZeroA, 8'h00, outDataA};
      1:       return {inReadyB, outValidB, outCarryB, outZeroB, 8'h00, outDataB};
      default: return {inReadyC, outValidC, outCarryC, outZeroC, outDataC};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole-result reference for the random W=16 run, computed in one go rather than step by step.
  function automatic void refModel(input logic [15:0] d, input int a, input logic [1:0] op,
                                   output logic [15:0] r, output logic c);
    logic [31:0] wide;
    wide = {16'h0000, d};
    case (op)
      SRL: r = d >> a;
      SRA: r = (d >> a) | (d[15] ? ~(16'hFFFF >> a) : 16'h0000);
      SLL: r = d << a;
      default: begin
        wide = (wide >> a) | (wide << (16 - a));
        r = wide[15:0];
      end
    endcase
    if (a == 0)                     c = 1'b0;
    else if (op == SRL || op == SRA) c = d[a-1];
    else if (op == SLL)             c = d[16-a];
    else                            c = r[15];
  endfunction

  // Waits for in_ready, presents one op for a single cycle, then scrambles the inputs and
  // counts negedges until out_valid; optionally consumes the result.
  task automatic applyStimulus(input int sel, input logic [15:0] d, input logic [3:0] amt,
                               input logic [1:0] op, input bit consume,
                               output logic [15:0] rd, output logic rc, output logic rz,
                               output int cyc);
    logic [19:0] p;
    int guard;
    guard = 0;
    @(negedge clk);
    p = peek(sel);
    while (!p[19] && guard < 20) begin
      @(negedge clk);
      p = peek(sel);
      guard++;
    end
    if (guard >= 20) checkOutput("readyTimeout", 32'(p[19]), 32'd1);
    inData = d; inAmt = amt; inOp = op;
    inValid[sel] = 1'b1;
    @(negedge clk);
    inValid[sel] = 1'b0;
    inData = ~d; inAmt = ~amt; inOp = ~op;
    cyc = 0;
    p = peek(sel);
    while (!p[18] && cyc < 40) begin
      @(negedge clk);
      p = peek(sel);
      cyc++;
    end
    if (cyc >= 40) checkOutput("validTimeout", 32'(p[18]), 32'd1);
    rd = p[15:0];
    rc = p[17];
    rz = p[16];
    if (consume) begin
      outReady[sel] = 1'b1;
      @(negedge clk);
      outReady[sel] = 1'b0;
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [3:0] amt;
    logic [1:0] op;
    logic [7:0] expData;
    logic       expCarry;
    int         expCyc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd, expD;
    logic        rc, rz, expC;
    logic [19:0] p;
    int          cyc;

    reset = 1'b1; inValid = '0; outReady = '0;
    inData = 16'h0000; inAmt = 4'h0; inOp = SRL;
    // Keep in_valid high during reset: nothing may be captured.
    inValid[0] = 1'b1;
    repeat (3) @(negedge clk);
    p = peek(0);
    checkOutput("rstReadyA", 32'(p[19]), 32'd0);
    checkOutput("rstValidA", 32'(p[18]), 32'd0);
    checkOutput("rstCarryA", 32'(p[17]), 32'd0);
    checkOutput("rstZeroA",  32'(p[16]), 32'd0);
    checkOutput("rstDataA",  32'(p[15:0]), 32'd0);
    inValid[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    p = peek(0);
    checkOutput("postRstReadyA", 32'(p[19]), 32'd1);
    checkOutput("postRstValidA", 32'(p[18]), 32'd0);

    // Hand-computed vectors, A = 8'b10110011.
    vecs.push_back('{0, 8'hB3, 4'd3, SRL, 8'h16, 1'b0, 3});
    vecs.push_back('{0, 8'hB3, 4'd3, SRA, 8'hF6, 1'b0, 3});
    vecs.push_back('{0, 8'hB3, 4'd3, SLL, 8'h98, 1'b1, 3});
    vecs.push_back('{0, 8'hB3, 4'd3, ROR, 8'h76, 1'b0, 3});
    vecs.push_back('{0, 8'h01, 4'd1, SRL, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 8'hB3, 4'd0, SLL, 8'hB3, 1'b0, 0});
    vecs.push_back('{1, 8'hB3, 4'd7, SRL, 8'h01, 1'b0, 2});
    vecs.push_back('{1, 8'hB3, 4'd0, SRL, 8'hB3, 1'b0, 0});
    vecs.push_back('{1, 8'hB3, 4'd5, ROR, 8'h9D, 1'b1, 2});
    vecs.push_back('{1, 8'h80, 4'd7, SRA, 8'hFF, 1'b0, 2});
    vecs.push_back('{1, 8'hB3, 4'd4, SLL, 8'h30, 1'b1, 1});
    vecs.push_back('{1, 8'h00, 4'd4, ROR, 8'h00, 1'b0, 1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, {8'h00, vecs[i].d}, vecs[i].amt, vecs[i].op, 1'b1, rd, rc, rz, cyc);
      checkOutput($sformatf("vec%0d.data", i), 32'(rd), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d.carry", i), 32'(rc), 32'(vecs[i].expCarry));
      checkOutput($sformatf("vec%0d.zero", i), 32'(rz), 32'(vecs[i].expData == 8'h00));
      checkOutput($sformatf("vec%0d.latency", i), 32'(cyc), 32'(vecs[i].expCyc));
    end

    // Backpressure: result must hold while in_valid pulses are refused.
    applyStimulus(0, 16'h00B3, 4'd3, SLL, 1'b0, rd, rc, rz, cyc);
    checkOutput("bpData", 32'(rd), 32'h98);
    for (int i = 0; i < 5; i++) begin
      p = peek(0);
      checkOutput($sformatf("bpHoldData%0d", i), 32'(p[15:0]), 32'h98);
      checkOutput($sformatf("bpHoldValid%0d", i), 32'(p[18]), 32'd1);
      checkOutput($sformatf("bpHoldCarry%0d", i), 32'(p[17]), 32'd1);
      checkOutput($sformatf("bpHoldReady%0d", i), 32'(p[19]), 32'd0);
      inData = 16'h0055; inAmt = 4'd1; inOp = SRL; inValid[0] = 1'b1;
      @(negedge clk);
      inValid[0] = 1'b0;
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
    p = peek(0);
    checkOutput("bpReleaseReady", 32'(p[19]), 32'd1);
    checkOutput("bpReleaseValid", 32'(p[18]), 32'd0);
    applyStimulus(0, 16'h00B3, 4'd3, SRA, 1'b1, rd, rc, rz, cyc);
    checkOutput("bpNextData", 32'(rd), 32'hF6);
    checkOutput("bpNextLatency", 32'(cyc), 32'd3);

    // Reset during the second SHIFT cycle of SLL by 3.
    @(negedge clk);
    inData = 16'h00B3; inAmt = 4'd3; inOp = SLL; inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    p = peek(0);
    checkOutput("abortShiftReady", 32'(p[19]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    p = peek(0);
    checkOutput("abortValid", 32'(p[18]), 32'd0);
    checkOutput("abortData", 32'(p[15:0]), 32'd0);
    checkOutput("abortReadyInReset", 32'(p[19]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    p = peek(0);
    checkOutput("abortIdleReady", 32'(p[19]), 32'd1);
    checkOutput("abortIdleValid", 32'(p[18]), 32'd0);
    checkOutput("abortIdleData", 32'(p[15:0]), 32'd0);
    applyStimulus(0, 16'h00B3, 4'd3, SLL, 1'b1, rd, rc, rz, cyc);
    checkOutput("afterAbortData", 32'(rd), 32'h98);
    checkOutput("afterAbortCarry", 32'(rc), 32'd1);

    // W=16, STEP=2 random ops.
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] d;
      logic [1:0]  op;
      int          a;
      d  = 16'($urandom);
      a  = $urandom_range(0, 15);
      op = 2'($urandom_range(0, 3));
      refModel(d, a, op, expD, expC);
      applyStimulus(2, d, 4'(a), op, 1'b1, rd, rc, rz, cyc);
      checkOutput($sformatf("rnd%0d.data", n), 32'(rd), 32'(expD));
      checkOutput($sformatf("rnd%0d.carry", n), 32'(rc), 32'(expC));
      checkOutput($sformatf("rnd%0d.zero", n), 32'(rz), 32'(expD == 16'h0000));
      checkOutput($sformatf("rnd%0d.latency", n), 32'(cyc), 32'((a + 1) / 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
